multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the 9-bit core; sits directly upstream of the datapath and ALU and drives every enable.
- Walks the shared `state` enum PC -> REGISTERREAD -> DATAMEM -> REGISTERWRITE, one state per cycle.
- Latches the instruction opcode and emits the shared `aluOp` code plus register-file, data-memory and PC controls.
- Provides start/done handshake and a retired-instruction counter.

Parameters:
- INSTR_W, 9, instruction width; opcode is instr[INSTR_W-1 -: 3].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins execution when idle.
- instr  in  INSTR_W  instruction from instruction memory; sampled in PC state.
- branch_cond  in  1  datapath flag, 1 = operand <= 0; used by BLQZ.
- halt  in  1  sampled in REGISTERWRITE; ends execution after the current instruction.
- mem_ready  in  1  data-memory ready; used only with CTRL_STALL_EN.
- cur_state  out  2  current `state` value.
- alu_op  out  3  `aluOp` of the latched opcode.
- ir_load  out  1  load instruction register.
- reg_wr_en  out  1  register-file write.
- mem_rd_en  out  1  data-memory read.
- mem_wr_en  out  1  data-memory write.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= branch target.
- done  out  1  level; high while halted after a run.
- instr_count  out  CNT_W  instructions retired since last start.

Behaviour:
- Reset (synchronous, active-high):
  - state=PC, running=0, opcode reg=ADD, done=0, instr_count=0.
  - All enables 0.
  - Reset mid-instruction aborts it; no writes occur in the reset cycle.
- Idle (running=0):
  - State held at PC; all enables 0.
  - start=1 sets running=1, clears done and instr_count; the first fetch occurs in the next cycle.
  - start while running is ignored.
- Running state machine (outputs are combinational from state register + opcode register):
  - PC: ir_load=1; opcode reg <= instr opcode. Next state REGISTERREAD.
  - REGISTERREAD: no enables; alu_op valid from this cycle onward. Next state DATAMEM.
  - DATAMEM: LD -> mem_rd_en=1; ST -> mem_wr_en=1; other opcodes -> no memory enables. Next state REGISTERWRITE.
  - REGISTERWRITE, writes: reg_wr_en=1 for ADD, XOR, AND, RSL, MOV, LD; 0 for ST and BLQZ.
  - REGISTERWRITE, PC update: for BLQZ with branch_cond=1, pc_load=1 and pc_inc=0; otherwise pc_inc=1. pc_load and pc_inc are never both 1.
  - REGISTERWRITE, retire: instr_count increments, saturating at all-ones. Next state PC.
- Latency: exactly 4 cycles per instruction without stalls. The `state` enum is used unmodified.
- halt=1 in REGISTERWRITE:
  - The instruction still completes: write and PC update happen, and it is counted.
  - Next cycle: running=0, done=1, state=PC.
- halt outside REGISTERWRITE is ignored.
- start and halt in the same REGISTERWRITE cycle: halt wins; start is ignored.

Optional Feature:
- Macro CTRL_STALL_EN.
- Defined: in DATAMEM with LD or ST, the FSM holds DATAMEM and keeps mem_rd_en/mem_wr_en asserted until mem_ready=1; it advances in the cycle mem_ready is seen high. Non-memory opcodes ignore mem_ready.
- Undefined: mem_ready is unused and DATAMEM always lasts 1 cycle.

Decomposition:
- `aluOp` and `state` come from the shared package `definitions`.
- Add OPC_MSB and the opcode-slice helper constants to the same package.
- One natural sub-module, ctrl_decode: purely combinational (opcode, state, branch_cond) -> enables and alu_op.
- The FSM, running flag and counter stay in multicycle_ctrl.

Test Plan:
- Reset, then no start for 5 cycles -> cur_state=PC, all enables 0, done=0, instr_count=0.
- start, instr opcode ADD -> ir_load in cycle 1; states PC,RR,DM,RW over 4 cycles; reg_wr_en and pc_inc in cycle 4; instr_count=1.
- Sequence LD, ST -> mem_rd_en=1 only in LD's DATAMEM; mem_wr_en=1 only in ST's DATAMEM; ST reg_wr_en=0; instr_count=2.
- BLQZ with branch_cond=1 -> pc_load=1, pc_inc=0. Same with branch_cond=0 -> pc_inc=1, pc_load=0. reg_wr_en=0 in both cases.
- halt=1 during the 3rd instruction's REGISTERWRITE -> reg write occurs; next cycle done=1, instr_count=3, idle; reset during a later DATAMEM aborts with no mem_wr_en.
- With CTRL_STALL_EN defined: LD, mem_ready low for 3 cycles -> DATAMEM held 4 cycles with mem_rd_en high; total instruction latency 7 cycles.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// definitions: shared state/aluOp enums and opcode-slice constants for the 9-bit core.
package definitions;
    typedef enum logic [1:0] {PC, REGISTERREAD, DATAMEM, REGISTERWRITE} state;
    typedef enum logic [2:0] {ADD, XOR, AND, RSL, MOV, LD, ST, BLQZ} aluOp;
    localparam int OPC_W = 3;
    localparam int INSTR_W_DEF = 9;
    localparam int OPC_MSB = INSTR_W_DEF - 1;
    localparam int OPC_LSB = OPC_MSB - OPC_W + 1;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational (opcode, state, branch_cond) -> datapath enables and alu_op.
module ctrl_decode
    import definitions::*;
(
    input  logic       run_i,
    input  state       state_i,
    input  aluOp       opcode_i,
    input  logic       branch_cond_i,
    output logic [2:0] alu_op_o,
    output logic       ir_load_o,
    output logic       reg_wr_en_o,
    output logic       mem_rd_en_o,
    output logic       mem_wr_en_o,
    output logic       pc_inc_o,
    output logic       pc_load_o
);
    logic dm, rw, taken;

    always_comb begin
        dm = run_i && state_i == DATAMEM;
        rw = run_i && state_i == REGISTERWRITE;
        taken = rw && opcode_i == BLQZ && branch_cond_i;
        alu_op_o = opcode_i;
        ir_load_o = run_i && state_i == PC;
        mem_rd_en_o = dm && opcode_i == LD;
        mem_wr_en_o = dm && opcode_i == ST;
        reg_wr_en_o = rw && opcode_i != ST && opcode_i != BLQZ;
        pc_load_o = taken;
        pc_inc_o = rw && !taken;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: PC->REGISTERREAD->DATAMEM->REGISTERWRITE sequencer with start/done and retire counter.
// Define CTRL_STALL_EN to hold DATAMEM on LD/ST until mem_ready.
module multicycle_ctrl
    import definitions::*;
#(
    parameter int INSTR_W = OPC_MSB + 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch_cond,
    input  logic               halt,
    input  logic               mem_ready,
    output logic [1:0]         cur_state,
    output logic [2:0]         alu_op,
    output logic               ir_load,
    output logic               reg_wr_en,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               done,
    output logic [CNT_W-1:0]   instr_count
);
    state             state_q, state_d;
    aluOp             opc_q, opc_d;
    logic             run_q, run_d, done_q, done_d, stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [INSTR_W-OPC_W-1:0] unused_instr;

    assign unused_instr = instr[INSTR_W-OPC_W-1:0];

`ifdef CTRL_STALL_EN
    assign stall = (opc_q == LD || opc_q == ST) && !mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        opc_d = opc_q;
        run_d = run_q;
        done_d = done_q;
        cnt_d = cnt_q;
        if (!run_q) begin
            state_d = PC;
            if (start) begin
                run_d = 1'b1;
                done_d = 1'b0;
                cnt_d = '0;
            end
        end else begin
            case (state_q)
                PC: begin
                    opc_d = aluOp'(instr[INSTR_W-1 -: OPC_W]);
                    state_d = REGISTERREAD;
                end
                REGISTERREAD: state_d = DATAMEM;
                DATAMEM: state_d = stall ? DATAMEM : REGISTERWRITE;
                REGISTERWRITE: begin
                    state_d = PC;
                    cnt_d = cnt_q + CNT_W'(~&cnt_q);
                    run_d = !halt;
                    done_d = halt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PC;
            opc_q <= ADD;
            run_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q <= opc_d;
            run_q <= run_d;
            done_q <= done_d;
            cnt_q <= cnt_d;
        end
    end

    // Enables are suppressed during a reset cycle so an aborted instruction never writes.
    ctrl_decode u_dec (
        .run_i         (run_q && !reset),
        .state_i       (state_q),
        .opcode_i      (opc_q),
        .branch_cond_i (branch_cond),
        .alu_op_o      (alu_op),
        .ir_load_o     (ir_load),
        .reg_wr_en_o   (reg_wr_en),
        .mem_rd_en_o   (mem_rd_en),
        .mem_wr_en_o   (mem_wr_en),
        .pc_inc_o      (pc_inc),
        .pc_load_o     (pc_load)
    );

    assign cur_state = state_q;
    assign done = done_q;
    assign instr_count = cnt_q;
endmodule
